if_stage: RTL

- Instruction-fetch stage of the pipelined DLX core. Sits directly upstream of decode and feeds the IF/ID pipeline register.
- Owns the PC and drives the instruction-memory address. Applies stall, redirect and squash, and detects the end-of-program trap (0x44000300).
- On the trap, drains the pipeline with NOPs and then raises halt so toplevel and benches can stop and dump data memory.

---
 rtl/if_stage_if.sv | 40 ++++
 rtl/if_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and IF/ID outputs.
// The fetch stage takes the master view; the surrounding core or bench takes the slave view.
interface if_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halt;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  redirect,
        input  redirect_target,
        output pc,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid,
        output halt
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output redirect,
        output redirect_target,
        input  pc,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid,
        input  halt
    );
endinterface

// File: rtl/if_stage.sv
// DLX instruction-fetch stage: owns the PC, fills IF/ID, and on the end-of-program
// trap drains the pipeline with NOPs before raising a registered halt.
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_HALT    = 32'h4400_0300,
    parameter logic [31:0] NOP_INSTR    = 32'h5400_0000,
    parameter logic [3:0]  DRAIN_CYCLES = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]  state_r, state_s;
    logic [3:0]  cnt_r,   cnt_s;
    logic [31:0] pc_r,    pc_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] pc4_r,   pc4_s;
    logic        valid_r, valid_s;
    logic        halt_r,  halt_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;

    // Redirect targets are word addresses; low bits from the branch unit are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    assign pc_plus4_s = pc_r + 32'd4;
    assign target_s   = word_align(bus.redirect_target);

    // Next-state logic for PC, IF/ID and the RUN/DRAIN/HALTED sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        pc4_s   = pc4_r;
        valid_s = valid_r;
        halt_s  = halt_r;
        case (state_r)
            ST_RUN: begin
                if (bus.redirect) begin
                    pc_s    = target_s;
                    instr_s = NOP_INSTR;
                    pc4_s   = 32'd0;
                    valid_s = 1'b0;
                end else if (bus.stall) begin
                    pc_s    = pc_r;
                end else if (bus.imem_data == TRAP_HALT) begin
                    // PC stays on the trap so nothing past it is ever fetched.
                    instr_s = bus.imem_data;
                    pc4_s   = pc_plus4_s;
                    valid_s = 1'b1;
                    cnt_s   = DRAIN_CYCLES;
                    state_s = ST_DRAIN;
                end else begin
                    instr_s = bus.imem_data;
                    pc4_s   = pc_plus4_s;
                    valid_s = 1'b1;
                    pc_s    = pc_plus4_s;
                end
            end
            ST_DRAIN: begin
                if (bus.redirect) begin
                    // Trap turned out to be on a mispredicted path.
                    pc_s    = target_s;
                    instr_s = NOP_INSTR;
                    pc4_s   = 32'd0;
                    valid_s = 1'b0;
                    cnt_s   = 4'd0;
                    state_s = ST_RUN;
                end else if (bus.stall) begin
                    cnt_s   = cnt_r;
                end else begin
                    instr_s = NOP_INSTR;
                    pc4_s   = 32'd0;
                    valid_s = 1'b0;
                    if (cnt_r <= 4'd1) begin
                        cnt_s   = 4'd0;
                        state_s = ST_HALTED;
                        halt_s  = 1'b1;
                    end else begin
                        cnt_s   = cnt_r - 4'd1;
                    end
                end
            end
            ST_HALTED: begin
                instr_s = NOP_INSTR;
                pc4_s   = 32'd0;
                valid_s = 1'b0;
                halt_s  = 1'b1;
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = 4'd0;
                pc_s    = RESET_PC;
                instr_s = NOP_INSTR;
                pc4_s   = 32'd0;
                valid_s = 1'b0;
                halt_s  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
            cnt_r   <= 4'd0;
            pc_r    <= RESET_PC;
            instr_r <= NOP_INSTR;
            pc4_r   <= 32'd0;
            valid_r <= 1'b0;
            halt_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pc_r    <= pc_s;
            instr_r <= instr_s;
            pc4_r   <= pc4_s;
            valid_r <= valid_s;
            halt_r  <= halt_s;
        end
    end

    assign bus.imem_addr  = pc_r;
    assign bus.pc         = pc_r;
    assign bus.ifid_instr = instr_r;
    assign bus.ifid_pc4   = pc4_r;
    assign bus.ifid_valid = valid_r;
    assign bus.halt       = halt_r;

endmodule
